// File: rtl/phase_sequencer_if.sv
// Bundle of control inputs and status outputs for the phase sequencer.
//   master: front end / bench side (drives ticks, buttons, table writes)
//   slave : sequencer side (drives lights, greenman, status)
interface phase_sequencer_if #(
    parameter int IDX_W  = 4,
    parameter int LIGHTS = 10,
    parameter int DUR_W  = 6
);
    logic              sec_tick;
    logic              blink_tick;
    logic              pause;
    logic              next;
    logic              dur_inc;
    logic              dur_dec;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DUR_W-1:0]  wr_dur;
    logic [LIGHTS-1:0] wr_on;
    logic [LIGHTS-1:0] wr_flash;
    logic              wr_man;
    logic              ins;
    logic              del;
    logic [LIGHTS-1:0] lights;
    logic              man_on;
    logic [IDX_W-1:0]  phase_idx;
    logic [DUR_W-1:0]  count;
    logic [DUR_W-1:0]  cur_dur;
    logic [IDX_W:0]    num_phases;
    logic              busy;

    modport master (
        output sec_tick, blink_tick, pause, next, dur_inc, dur_dec,
               wr_en, wr_idx, wr_dur, wr_on, wr_flash, wr_man, ins, del,
        input  lights, man_on, phase_idx, count, cur_dur, num_phases, busy
    );

    modport slave (
        input  sec_tick, blink_tick, pause, next, dur_inc, dur_dec,
               wr_en, wr_idx, wr_dur, wr_on, wr_flash, wr_man, ins, del,
        output lights, man_on, phase_idx, count, cur_dur, num_phases, busy
    );
endinterface

// File: rtl/phase_sequencer.sv
// Programmable phase sequencer: steps through a table of light phases on a
// 1 Hz tick, with pause, skip, duration trim, random-access writes and
// multi-cycle insert/delete of table entries.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    phase_sequencer_if.slave (ticks, buttons, table write port,
//          lights / greenman / status outputs)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal sequencing; accepts ticks, buttons, writes, ins/del
// SHIFT_INS | moving entries up one slot, then blanking entry phase_idx
// SHIFT_DEL | moving entries down one slot over entry phase_idx
module phase_sequencer #(
    parameter int MAX_PHASES = 16,
    parameter int IDX_W      = 4,
    parameter int LIGHTS     = 10,
    parameter int DUR_W      = 6
) (
    input  logic                clk,
    input  logic                reset,
    phase_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {RUN, SHIFT_INS, SHIFT_DEL} state_t;

    localparam logic [IDX_W:0]   MAX_N   = (IDX_W+1)'(MAX_PHASES);
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    state_t            state_q;
    logic [DUR_W-1:0]  dur_q   [MAX_PHASES];
    logic [LIGHTS-1:0] on_q    [MAX_PHASES];
    logic [LIGHTS-1:0] flash_q [MAX_PHASES];
    logic [MAX_PHASES-1:0] man_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  p_q;
    logic [IDX_W:0]    num_q;
    logic [DUR_W-1:0]  count_q;
    logic              blink_q;
    logic              busy_q;
    logic [LIGHTS-1:0] lights_q;
    logic              man_on_q;

    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  idx_d;
    logic              wr_ok;
    logic              wr_cur;
    logic [DUR_W-1:0]  trim_dur;
    logic [DUR_W-1:0]  cur_dur_d;
    logic [DUR_W-1:0]  tgt_dur;
    logic              advance;
    logic              start_ins;
    logic              start_del;
    logic [DUR_W-1:0]  count_d;

    function automatic logic [DUR_W-1:0] eff(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    always_comb begin
        last_idx  = IDX_W'(num_q - (IDX_W+1)'(1));
        idx_d     = (idx_q == last_idx) ? '0 : idx_q + IDX_W'(1);
        wr_ok     = bus.wr_en && ({1'b0, bus.wr_idx} < num_q);
        wr_cur    = wr_ok && (bus.wr_idx == idx_q);

        trim_dur = dur_q[idx_q];
        if (bus.dur_inc && !bus.dur_dec && trim_dur != DUR_MAX)
            trim_dur = trim_dur + DUR_W'(1);
        else if (bus.dur_dec && !bus.dur_inc && trim_dur != '0)
            trim_dur = trim_dur - DUR_W'(1);
        cur_dur_d = wr_cur ? bus.wr_dur : trim_dur;

        // The advance target sees this cycle's table update, so a write or
        // trim landing on the entry being entered is already reflected.
        if (wr_ok && bus.wr_idx == idx_d)
            tgt_dur = bus.wr_dur;
        else if (idx_d == idx_q)
            tgt_dur = cur_dur_d;
        else
            tgt_dur = dur_q[idx_d];

        advance   = bus.next || (bus.sec_tick && !bus.pause && count_q <= DUR_W'(1));
        start_ins = bus.ins && !bus.del && (num_q < MAX_N);
        start_del = bus.del && !bus.ins && (num_q > (IDX_W+1)'(1));

        count_d = count_q;
        if (advance)
            count_d = eff(tgt_dur);
        else if (bus.sec_tick && !bus.pause)
            count_d = count_q - DUR_W'(1);
        if (!advance && count_d > eff(cur_dur_d))
            count_d = eff(cur_dur_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_PHASES; i++) begin
                dur_q[i]   <= DUR_W'(1);
                on_q[i]    <= '0;
                flash_q[i] <= '0;
            end
            man_q    <= '0;
            state_q  <= RUN;
            idx_q    <= '0;
            p_q      <= '0;
            num_q    <= (IDX_W+1)'(1);
            count_q  <= DUR_W'(1);
            blink_q  <= 1'b1;
            busy_q   <= 1'b0;
            lights_q <= '0;
            man_on_q <= 1'b0;
        end else begin
            if (bus.blink_tick)
                blink_q <= ~blink_q;

            // Outputs freeze while the table is being restructured.
            if (state_q == RUN) begin
                lights_q <= on_q[idx_q] & ~(flash_q[idx_q] & {LIGHTS{~blink_q}});
                man_on_q <= man_q[idx_q];
            end

            case (state_q)
                RUN: begin
                    if (start_ins) begin
                        state_q <= SHIFT_INS;
                        p_q     <= IDX_W'(num_q);
                        busy_q  <= 1'b1;
                    end else if (start_del) begin
                        state_q <= SHIFT_DEL;
                        p_q     <= idx_q;
                        busy_q  <= 1'b1;
                    end else begin
                        if (wr_ok) begin
                            dur_q[bus.wr_idx]   <= bus.wr_dur;
                            on_q[bus.wr_idx]    <= bus.wr_on;
                            flash_q[bus.wr_idx] <= bus.wr_flash;
                            man_q[bus.wr_idx]   <= bus.wr_man;
                        end
                        if (!wr_cur)
                            dur_q[idx_q] <= trim_dur;
                        if (advance)
                            idx_q <= idx_d;
                        count_q <= count_d;
                    end
                end
                SHIFT_INS: begin
                    if (p_q == idx_q) begin
                        dur_q[p_q]   <= DUR_W'(1);
                        on_q[p_q]    <= '0;
                        flash_q[p_q] <= '0;
                        man_q[p_q]   <= 1'b0;
                        num_q        <= num_q + (IDX_W+1)'(1);
                        count_q      <= DUR_W'(1);
                        state_q      <= RUN;
                        busy_q       <= 1'b0;
                    end else begin
                        dur_q[p_q]   <= dur_q[p_q - IDX_W'(1)];
                        on_q[p_q]    <= on_q[p_q - IDX_W'(1)];
                        flash_q[p_q] <= flash_q[p_q - IDX_W'(1)];
                        man_q[p_q]   <= man_q[p_q - IDX_W'(1)];
                        p_q          <= p_q - IDX_W'(1);
                    end
                end
                SHIFT_DEL: begin
                    if (p_q == last_idx) begin
                        // Table already shifted; the vacated top slot is left
                        // stale because it is outside the active range.
                        num_q   <= num_q - (IDX_W+1)'(1);
                        if (idx_q == last_idx) begin
                            idx_q   <= '0;
                            count_q <= eff(dur_q[0]);
                        end else begin
                            count_q <= eff(dur_q[idx_q]);
                        end
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        dur_q[p_q]   <= dur_q[p_q + IDX_W'(1)];
                        on_q[p_q]    <= on_q[p_q + IDX_W'(1)];
                        flash_q[p_q] <= flash_q[p_q + IDX_W'(1)];
                        man_q[p_q]   <= man_q[p_q + IDX_W'(1)];
                        p_q          <= p_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lights     = lights_q;
    assign bus.man_on     = man_on_q;
    assign bus.phase_idx  = idx_q;
    assign bus.count      = count_q;
    assign bus.cur_dur    = dur_q[idx_q];
    assign bus.num_phases = num_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;
    localparam int MAXP   = 16;
    localparam int IDX_W  = 4;
    localparam int LIGHTS = 10;
    localparam int DUR_W  = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    phase_sequencer_if #(.IDX_W(IDX_W), .LIGHTS(LIGHTS), .DUR_W(DUR_W)) bus ();

    phase_sequencer #(.MAX_PHASES(MAXP), .IDX_W(IDX_W), .LIGHTS(LIGHTS), .DUR_W(DUR_W))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: table kept as a queue of entries
    typedef struct packed {
        logic [DUR_W-1:0]  dur;
        logic [LIGHTS-1:0] on;
        logic [LIGHTS-1:0] flash;
        logic              man;
    } ent_t;

    ent_t              m_tab[$];
    int                m_idx, m_cnt, m_busy_left, m_op;
    bit                m_blink;
    logic [LIGHTS-1:0] m_lights;
    logic              m_man;
    ent_t              e_m;
    int                n_m, d_m;
    bit                wv_m, adv_m;

    function automatic int eff(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_tab.delete();
            e_m = '0;
            e_m.dur = DUR_W'(1);
            for (int i = 0; i < MAXP; i++) m_tab.push_back(e_m);
            while (m_tab.size() > 1) m_tab.pop_back();
            m_idx = 0; m_cnt = 1; m_busy_left = 0; m_op = 0;
            m_blink = 1'b1; m_lights = '0; m_man = 1'b0;
        end else begin
            if (m_busy_left == 0) begin
                e_m = m_tab[m_idx];
                m_lights = e_m.on & ~(e_m.flash & {LIGHTS{~m_blink}});
                m_man = e_m.man;
            end
            if (bus.blink_tick) m_blink = !m_blink;
            n_m = m_tab.size();
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    if (m_op == 1) begin
                        e_m = '0;
                        e_m.dur = DUR_W'(1);
                        m_tab.insert(m_idx, e_m);
                        m_cnt = 1;
                    end else begin
                        m_tab.delete(m_idx);
                        if (m_idx >= m_tab.size()) m_idx = 0;
                        m_cnt = eff(int'(m_tab[m_idx].dur));
                    end
                end
            end else if (bus.ins && !bus.del && n_m < MAXP) begin
                m_busy_left = n_m - m_idx + 1;
                m_op = 1;
            end else if (bus.del && !bus.ins && n_m > 1) begin
                m_busy_left = n_m - m_idx;
                m_op = 2;
            end else begin
                wv_m = bus.wr_en && (int'(bus.wr_idx) < n_m);
                if (wv_m) begin
                    e_m.dur = bus.wr_dur; e_m.on = bus.wr_on;
                    e_m.flash = bus.wr_flash; e_m.man = bus.wr_man;
                    m_tab[bus.wr_idx] = e_m;
                end
                if (!(wv_m && int'(bus.wr_idx) == m_idx) && (bus.dur_inc != bus.dur_dec)) begin
                    e_m = m_tab[m_idx];
                    d_m = int'(e_m.dur);
                    if (bus.dur_inc && d_m < 63) d_m++;
                    if (bus.dur_dec && d_m > 0) d_m--;
                    e_m.dur = DUR_W'(d_m);
                    m_tab[m_idx] = e_m;
                end
                adv_m = bus.next || (bus.sec_tick && !bus.pause && m_cnt <= 1);
                if (adv_m) begin
                    m_idx = (m_idx == n_m - 1) ? 0 : m_idx + 1;
                    m_cnt = eff(int'(m_tab[m_idx].dur));
                end else begin
                    if (bus.sec_tick && !bus.pause) m_cnt--;
                    if (m_cnt > eff(int'(m_tab[m_idx].dur))) m_cnt = eff(int'(m_tab[m_idx].dur));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lights", bus.lights, m_lights);
            chk("man_on", bus.man_on, m_man);
            chk("phase_idx", bus.phase_idx, m_idx);
            chk("count", bus.count, m_cnt);
            chk("num_phases", bus.num_phases, m_tab.size());
            chk("busy", bus.busy, (m_busy_left > 0));
            if (m_busy_left == 0) chk("cur_dur", bus.cur_dur, m_tab[m_idx].dur);
        end
    end

    // ---------------- stimulus helpers
    task automatic clr();
        bus.sec_tick = 0; bus.blink_tick = 0; bus.next = 0;
        bus.dur_inc = 0; bus.dur_dec = 0; bus.wr_en = 0;
        bus.ins = 0; bus.del = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        clr();
    endtask

    task automatic wr(input int idx, input int dur, input int on, input int fl, input bit man);
        bus.wr_en = 1; bus.wr_idx = IDX_W'(idx); bus.wr_dur = DUR_W'(dur);
        bus.wr_on = LIGHTS'(on); bus.wr_flash = LIGHTS'(fl); bus.wr_man = man;
        cyc();
    endtask

    task automatic run_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
    endtask

    int exp_ph[10]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    int exp_cnt[10] = '{2, 1, 2, 1, 3, 2, 1, 2, 1, 3};
    int exp_lt[4]   = '{32'h3FE, 32'h3FF, 32'h3FE, 32'h3FF};
    int exp_walk[4] = '{9, 10, 7, 8};
    int nb;

    initial begin
        clr();
        bus.pause = 0; bus.wr_idx = '0; bus.wr_dur = '0;
        bus.wr_on = '0; bus.wr_flash = '0; bus.wr_man = 0;
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        chk_en = 1;

        chk("rst_num", bus.num_phases, 1);
        chk("rst_idx", bus.phase_idx, 0);
        chk("rst_count", bus.count, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lights", bus.lights, 0);
        chk("rst_cur_dur", bus.cur_dur, 1);

        // two-phase table: 3 s then 2 s
        bus.ins = 1; cyc(); run_busy(nb);
        chk("ins1_busy", nb, 2);
        wr(0, 3, 0, 0, 0);
        wr(1, 2, 0, 0, 0);
        bus.next = 1; cyc();
        bus.next = 1; cyc();
        chk("seq_start_count", bus.count, 3);
        for (int i = 0; i < 10; i++) begin
            bus.sec_tick = 1; cyc();
            chk("seq_phase", bus.phase_idx, exp_ph[i]);
            chk("seq_count", bus.count, exp_cnt[i]);
        end

        // pause freezes countdown; next still advances
        bus.pause = 1;
        repeat (5) begin bus.sec_tick = 1; cyc(); end
        chk("pause_count", bus.count, 3);
        bus.next = 1; cyc();
        chk("pause_next_idx", bus.phase_idx, 1);
        chk("pause_next_count", bus.count, 2);
        bus.pause = 0;

        // duration trim saturation and clamp
        wr(1, 63, 0, 0, 0);
        bus.dur_inc = 1; cyc();
        chk("inc_sat", bus.cur_dur, 63);
        wr(0, 5, 0, 0, 0);
        bus.next = 1; cyc();
        chk("dur5_count", bus.count, 5);
        bus.dur_dec = 1; cyc();
        chk("dec_dur", bus.cur_dur, 4);
        chk("dec_clamp", bus.count, 4);
        bus.dur_inc = 1; bus.dur_dec = 1; cyc();
        chk("incdec_dur", bus.cur_dur, 4);

        // flashing light and greenman
        wr(0, 4, 32'h3FF, 32'h001, 1);
        cyc();
        chk("lights_on", bus.lights, 32'h3FF);
        chk("man_on", bus.man_on, 1);
        for (int i = 0; i < 4; i++) begin
            bus.blink_tick = 1; cyc(); cyc();
            chk("blink_lights", bus.lights, exp_lt[i]);
        end

        // four-entry table, insert and delete at phase 1
        bus.ins = 1; cyc(); run_busy(nb);
        bus.ins = 1; cyc(); run_busy(nb);
        chk("num4", bus.num_phases, 4);
        for (int i = 0; i < 4; i++) wr(i, 7 + i, 32'h010 << i, 0, i[0]);
        bus.next = 1; cyc();
        chk("idx1_count", bus.count, 8);
        bus.ins = 1; cyc(); run_busy(nb);
        chk("ins_busy4", nb, 4);
        chk("ins_num5", bus.num_phases, 5);
        chk("ins_blank_dur", bus.cur_dur, 1);
        chk("ins_count", bus.count, 1);
        cyc();
        chk("ins_blank_lights", bus.lights, 0);
        bus.del = 1; cyc(); run_busy(nb);
        chk("del_busy4", nb, 4);
        chk("del_num4", bus.num_phases, 4);
        chk("del_cur_dur", bus.cur_dur, 8);
        chk("del_count", bus.count, 8);
        for (int i = 0; i < 4; i++) begin
            bus.next = 1; cyc();
            chk("restored_dur", bus.cur_dur, exp_walk[i]);
        end

        // reset in the middle of a delete
        bus.del = 1; cyc(); cyc();
        chk("del_busy_mid", bus.busy, 1);
        reset = 1; cyc(); reset = 0;
        chk("rst_mid_num", bus.num_phases, 1);
        chk("rst_mid_busy", bus.busy, 0);

        // capacity limits
        for (int i = 0; i < MAXP - 1; i++) begin
            bus.ins = 1; cyc(); run_busy(nb);
        end
        chk("full_num", bus.num_phases, MAXP);
        bus.ins = 1; cyc();
        chk("full_ins_busy", bus.busy, 0);
        chk("full_ins_num", bus.num_phases, MAXP);
        reset = 1; cyc(); reset = 0;
        bus.del = 1; cyc();
        chk("one_del_busy", bus.busy, 0);
        chk("one_del_num", bus.num_phases, 1);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus.sec_tick   = ($urandom_range(0, 3) == 0);
            bus.blink_tick = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
            bus.next    = ($urandom_range(0, 15) == 0);
            bus.dur_inc = ($urandom_range(0, 9) == 0);
            bus.dur_dec = ($urandom_range(0, 9) == 0);
            bus.wr_en   = ($urandom_range(0, 5) == 0);
            bus.wr_idx  = IDX_W'($urandom_range(0, MAXP - 1));
            bus.wr_dur  = ($urandom_range(0, 3) == 0) ? DUR_W'($urandom_range(0, 63))
                                                      : DUR_W'($urandom_range(0, 4));
            bus.wr_on    = LIGHTS'($urandom);
            bus.wr_flash = LIGHTS'($urandom);
            bus.wr_man   = $urandom_range(0, 1) == 1;
            bus.ins   = ($urandom_range(0, 24) == 0);
            bus.del   = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        clr();
        reset = 0;
        bus.pause = 0;
        repeat (40) @(negedge clk);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised successor to the fixed-table traffic controller. Holds a programmable table of up to MAX_PHASES phases, each with a duration, per-light on and flash bits, and a pedestrian (greenman) bit. Steps through the phases on a one-second tick and supports pause, skip, duration trim, random-access write, and multi-cycle insert/delete of phases. Sits between the debounce/one-shot front end and the light, seven-segment and greenman outputs.

Parameters:
MAX_PHASES, 16, table depth (power of 2)
IDX_W, 4, log2(MAX_PHASES)
LIGHTS, 10, light outputs per phase
DUR_W, 6, duration width in seconds

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
sec_tick  in  1  one-cycle pulse, 1 Hz
blink_tick  in  1  one-cycle pulse, toggles flash phase
pause  in  1  level; freezes countdown
next  in  1  pulse; advance phase now
dur_inc  in  1  pulse; current phase duration +1
dur_dec  in  1  pulse; current phase duration -1
wr_en  in  1  pulse; write table entry
wr_idx  in  IDX_W  entry to write
wr_dur  in  DUR_W  written duration
wr_on  in  LIGHTS  written on bits
wr_flash  in  LIGHTS  written flash bits
wr_man  in  1  written greenman bit
ins  in  1  pulse; insert blank phase at phase_idx
del  in  1  pulse; delete phase at phase_idx
lights  out  LIGHTS  driven lights
man_on  out  1  greenman enable
phase_idx  out  IDX_W  current phase
count  out  DUR_W  seconds remaining
cur_dur  out  DUR_W  duration of current entry
num_phases  out  IDX_W+1  active entries, range 1..MAX_PHASES
busy  out  1  insert/delete in progress

Behaviour:
- Reset values: num_phases=1; every entry has dur=1 and on/flash/man=0; phase_idx=0; count=1; blink_phase=1; state=RUN; busy=0; lights=0; man_on=0.
- Effective duration: eff = max(dur,1).
- State RUN, next: phase_idx <= (phase_idx==num_phases-1) ? 0 : phase_idx+1. count <= eff of the new entry. Applies even when paused.
- State RUN, sec_tick with !pause and no next: if count>1, count--; otherwise advance exactly as for next.
- next and sec_tick in the same cycle: a single advance.
- dur_inc / dur_dec act on the current entry:
  - saturate at 2^DUR_W-1 and at 0;
  - both asserted in the same cycle: no change;
  - if count exceeds the new eff, count is clamped to it in the same cycle.
- wr_en:
  - ignored when wr_idx>=num_phases;
  - overrides dur_inc/dur_dec when wr_idx==phase_idx;
  - writing the current entry clamps count as above.
- lights = on & ~(flash & ~blink_phase). blink_phase toggles on blink_tick. Outputs are registered, so an entry change appears one cycle later.
- man_on = man bit of the current entry.
- ins, accepted only if num_phases<MAX_PHASES:
  - go to SHIFT_INS with pointer p=num_phases and busy=1;
  - each cycle: if p>phase_idx, entry[p]<=entry[p-1]; if p==phase_idx, entry[p]<=blank (dur=1, all bits 0);
  - p decrements each cycle; after the p==phase_idx cycle, num_phases++, count=1, return to RUN;
  - busy lasts num_phases-phase_idx+1 cycles.
- del, accepted only if num_phases>1:
  - go to SHIFT_DEL with p=phase_idx and busy=1;
  - each cycle: if p<num_phases-1, entry[p]<=entry[p+1]; p increments;
  - done after the p==num_phases-1 cycle, so busy lasts num_phases-phase_idx cycles;
  - on completion: num_phases--; if the old phase_idx was the last entry, phase_idx=0; count=eff of the new current entry.
- ins and del in the same cycle: both ignored.
- While busy: sec_tick, next, dur_inc, dur_dec, wr_en, ins and del are all ignored. lights hold their last value.
- reset during SHIFT_*: full reset values, RUN, busy=0.

Test Plan:
- Reset, write entry0 dur=3 and entry1 dur=2 (after inserting entry1), 10 sec_ticks -> phase sequence 0,0,0,1,1,0,0,0,1,1; count 3,2,1,2,1,...
- pause=1 with 5 sec_ticks -> count unchanged; next pulse while paused -> phase_idx+1, count=eff.
- dur=63 then dur_inc -> stays 63; dur=5 with count=5, then dur_dec -> dur=4, count=4; dur_inc+dur_dec together -> unchanged.
- on=10'h3FF, flash=10'h001, 4 blink_ticks -> lights alternates 3FF, 3FE; man bit 1 -> man_on=1.
- num_phases=4, phase_idx=1: ins -> busy exactly 4 cycles, num_phases=5, entries shifted up, new entry1 blank. Then del -> busy 4 cycles, original table restored.
- Assert reset in the 2nd busy cycle of del -> num_phases=1, busy=0. ins at MAX_PHASES and del at 1 phase -> ignored, busy stays 0.
